// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and default parameter values.
package reset_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_RELEASE   = 3'd1,
        ST_RUN       = 3'd2,
        ST_SOFT_HOLD = 3'd3,
        ST_SOFT_WAIT = 3'd4
    } state_e;

    localparam int DEF_N_STAGES    = 4;
    localparam int DEF_SYNC_DEPTH  = 2;
    localparam int DEF_HOLD_CYCLES = 16;

endpackage

// File: rtl/reset_sequencer_sync.sv
// Reset synchronizer: asserts asynchronously, deasserts after DEPTH clock edges.
module reset_sync #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic rst_sync_o
);

    logic [DEPTH-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], 1'b1};
        end
    end

    assign rst_sync_o = sync_q[DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// Ordered release of per-subsystem resets from the board master reset, with a
// soft-reset request/acknowledge handshake for re-sequencing without the master reset.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int N_STAGES    = DEF_N_STAGES,
    parameter int SYNC_DEPTH  = DEF_SYNC_DEPTH,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                soft_req,
    output logic                soft_ack,
    output logic [N_STAGES-1:0] stage_nreset,
    output logic                ready
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam int IDX_W = $clog2(N_STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_STAGES);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [N_STAGES-1:0]   stage_q, stage_d;
    logic                  ready_q, ready_d;
    logic                  ack_q, ack_d;
    logic                  rst_sync;
    logic                  step_done;

    reset_sync #(
        .DEPTH (SYNC_DEPTH)
    ) u_reset_sync (
        .clk        (clk),
        .rst_n      (nreset),
        .rst_sync_o (rst_sync)
    );

    assign step_done = (cnt_q == CNT_LAST);

    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stage_d = stage_q;
        ready_d = ready_q;
        ack_d   = ack_q;

        case (state_q)
            // The first release step supplies the initial hold interval after deassertion.
            ST_HOLD: begin
                stage_d = '0;
                ready_d = 1'b0;
                ack_d   = 1'b0;
                cnt_d   = '0;
                idx_d   = '0;
                if (rst_sync) begin
                    state_d = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                if (step_done) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        ready_d = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        for (int i = 0; i < N_STAGES; i++) begin
                            if (idx_q == IDX_W'(i)) begin
                                stage_d[i] = 1'b1;
                            end
                        end
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RUN: begin
                if (soft_req) begin
                    stage_d = '0;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SOFT_HOLD;
                end
            end

            ST_SOFT_HOLD: begin
                if (step_done) begin
                    ack_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SOFT_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_SOFT_WAIT: begin
                if (!soft_req) begin
                    ack_d   = 1'b0;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_RELEASE;
                end
            end

            default: begin
                stage_d = '0;
                ready_d = 1'b0;
                ack_d   = 1'b0;
                cnt_d   = '0;
                idx_d   = '0;
                state_d = ST_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            stage_q <= '0;
            ready_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            ready_q <= ready_d;
            ack_q   <= ack_d;
        end
    end

    assign stage_nreset = stage_q;
    assign ready        = ready_q;
    assign soft_ack     = ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: timestamp-based reference model checked every cycle,
// directed scenario order with randomized timing.
module tb_reset_sequencer;

    localparam int N  = 4;
    localparam int S  = 2;
    localparam int H  = 16;
    localparam int N2 = 1;
    localparam int S2 = 3;
    localparam int H2 = 1;

    // Reference state: sequence start edge (stage k rises at ss+(k+1)*hc) and
    // soft-request acceptance edge e (-1 when no soft reset is in progress).
    typedef struct {
        int started;
        int ss;
        int e;
    } model_t;

    logic          clk      = 1'b0;
    logic          nreset   = 1'b0;
    logic          soft_req = 1'b0;
    logic          soft_ack;
    logic [N-1:0]  stage_nreset;
    logic          ready;

    logic          nreset2   = 1'b0;
    logic          soft_req2 = 1'b0;
    logic          soft_ack2;
    logic [N2-1:0] stage2;
    logic          ready2;

    int     total = 0;
    int     bad   = 0;
    int     n     = 0;
    model_t m;
    model_t m2;

    always #5 clk = ~clk;

    reset_sequencer #(
        .N_STAGES    (N),
        .SYNC_DEPTH  (S),
        .HOLD_CYCLES (H)
    ) dut (
        .clk          (clk),
        .nreset       (nreset),
        .soft_req     (soft_req),
        .soft_ack     (soft_ack),
        .stage_nreset (stage_nreset),
        .ready        (ready)
    );

    reset_sequencer #(
        .N_STAGES    (N2),
        .SYNC_DEPTH  (S2),
        .HOLD_CYCLES (H2)
    ) dut2 (
        .clk          (clk),
        .nreset       (nreset2),
        .soft_req     (soft_req2),
        .soft_ack     (soft_ack2),
        .stage_nreset (stage2),
        .ready        (ready2)
    );

    function automatic logic [5:0] expect_out(model_t md, int edge_n, int ns, int hc);
        logic [5:0] r;
        r = '0;
        if (md.started != 0) begin
            if (md.e < 0) begin
                for (int k = 0; k < ns; k++) begin
                    r[k] = (edge_n >= md.ss + (k + 1) * hc);
                end
                r[4] = (edge_n >= md.ss + (ns + 1) * hc);
            end else begin
                r[5] = (edge_n >= md.e + hc);
            end
        end
        return r;
    endfunction

    function automatic model_t step(model_t md, int edge_n, logic nrst, logic req,
                                    int ns, int hc, int sd);
        model_t r;
        logic   ready_prev;
        logic   ack_prev;
        r = md;
        if (!nrst) begin
            r.started = 0;
            r.e       = -1;
        end else if (md.started == 0) begin
            r.started = 1;
            r.ss      = edge_n + sd;
            r.e       = -1;
        end else begin
            ready_prev = (md.e < 0) && (edge_n - 1 >= md.ss + (ns + 1) * hc);
            ack_prev   = (md.e >= 0) && (edge_n - 1 >= md.e + hc);
            if (ready_prev && req) begin
                r.e = edge_n;
            end else if (ack_prev && !req) begin
                r.ss = edge_n;
                r.e  = -1;
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        n++;
        m  = step(m, n, nreset, soft_req, N, H, S);
        m2 = step(m2, n, nreset2, soft_req2, N2, H2, S2);
        @(negedge clk);
        check($sformatf("dut1_edge_%0d", n), {26'b0, soft_ack, ready, stage_nreset},
              {26'b0, expect_out(m, n, N, H)});
        check($sformatf("dut2_edge_%0d", n), {26'b0, soft_ack2, ready2, 3'b000, stage2},
              {26'b0, expect_out(m2, n, N2, H2)});
    endtask

    // Called just after a falling clock edge; the low pulse lands well before the next rise.
    task automatic async_low(input string tag);
        #2 nreset = 1'b0;
        m.started = 0;
        m.e       = -1;
        #1;
        check(tag, {26'b0, soft_ack, ready, stage_nreset}, {26'b0, expect_out(m, n, N, H)});
    endtask

    task automatic glitch_low(input string tag);
        async_low(tag);
        #1 nreset = 1'b1;
    endtask

    task automatic wait_ready(input int limit);
        logic [5:0] e;
        for (int i = 0; i < limit; i++) begin
            e = expect_out(m, n, N, H);
            if (e[4]) break;
            cycle();
        end
        check("ready_reached", {31'b0, ready}, 32'd1);
    endtask

    int rdy_cnt;
    int ack_cnt;

    initial begin
        m  = '{0, 0, -1};
        m2 = '{0, 0, -1};

        // Reset state with both masters held low
        repeat (3) cycle();

        // Power-up sequence
        nreset = 1'b1;
        repeat (90) cycle();

        // Abort mid-release at t0+40, then a randomly placed abort
        async_low("abort_in_run");
        repeat (3) cycle();
        nreset = 1'b1;
        repeat (40) cycle();
        async_low("abort_t0_40");
        repeat (2) cycle();
        nreset = 1'b1;
        repeat ($urandom_range(5, 80)) cycle();
        async_low("abort_random");
        repeat ($urandom_range(1, 4)) cycle();
        nreset = 1'b1;
        wait_ready(200);

        // Soft resets with random request timing; odd iterations drop during SOFT_HOLD
        for (int it = 0; it < 4; it++) begin
            repeat ($urandom_range(0, 5)) cycle();
            soft_req = 1'b1;
            if (it % 2 == 1) begin
                repeat ($urandom_range(1, H - 1)) cycle();
            end else begin
                repeat (H + $urandom_range(1, 20)) cycle();
            end
            soft_req = 1'b0;
            repeat (2) cycle();
            wait_ready(200);
        end

        // Early request held through power-up: ready must pulse for exactly one cycle
        async_low("early_req_reset");
        soft_req = 1'b1;
        repeat (2) cycle();
        nreset  = 1'b1;
        rdy_cnt = 0;
        ack_cnt = 0;
        repeat (110) begin
            cycle();
            if (ready) rdy_cnt++;
            if (soft_ack) ack_cnt++;
        end
        check("early_ready_width", rdy_cnt, 32'd1);
        check("early_ack_seen", {31'b0, (ack_cnt > 0)}, 32'd1);
        soft_req = 1'b0;
        repeat (2) cycle();
        wait_ready(200);

        // Master reset while waiting in SOFT_WAIT
        soft_req = 1'b1;
        repeat (H + 5) cycle();
        check("soft_wait_ack_high", {31'b0, soft_ack}, 32'd1);
        async_low("reset_in_soft_wait");
        soft_req = 1'b0;
        repeat (3) cycle();
        nreset = 1'b1;
        repeat (90) cycle();

        // Sub-cycle glitch on the master reset while running
        glitch_low("glitch_in_run");
        repeat (90) cycle();

        // Minimal configuration: N_STAGES=1, HOLD_CYCLES=1, SYNC_DEPTH=3
        nreset2 = 1'b1;
        repeat (10) cycle();
        #2 nreset2 = 1'b0;
        m2.started = 0;
        m2.e       = -1;
        #1;
        check("dut2_async_low", {30'b0, ready2, stage2}, 32'd0);
        repeat (2) cycle();
        nreset2 = 1'b1;
        repeat (8) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
